// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port block-RAM controller with a valid/ready request
// handshake, byte-lane masked writes done as read-modify-write, a one-cycle
// read-data-valid strobe and a memory-clear sequencer (after reset or on demand).
module ram_ctrl #(
  parameter int                        DATA_WIDTH     = 16,
  parameter int                        ADDR_WIDTH     = 11,
  parameter int                        DEPTH          = 2048,
  parameter int                        CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0]     CLEAR_VALUE    = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic [DATA_WIDTH/8-1:0]      mask,
  input  logic                         write_enable,
  input  logic                         req,
  output logic                         ready,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  input  logic                         clear_start,
  output logic                         clearing
);

  localparam int MW = DATA_WIDTH / 8;
  // Sweep counter is one bit wider than the address so DEPTH == 2**ADDR_WIDTH
  // still reaches its terminal value without wrapping.
  localparam int CW = ADDR_WIDTH + 1;
  // Index width of the storage array itself.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RMW   = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0] lat_data_q, lat_data_d;
  logic [MW-1:0]         lat_mask_q, lat_mask_d;
  logic                  lat_in_range_q, lat_in_range_d;
  logic                  data_valid_q, data_valid_d;
  logic                  rd_zero_q, rd_zero_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  // Storage and its registered read port (kept free of reset so it maps to BlockRAM).
  logic [DATA_WIDTH-1:0] storage [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd_q;
  logic                  mem_we;
  logic                  mem_re;
  logic [IW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] merged;

  logic accept;
  logic in_range;
  logic mask_full;
  logic mask_none;

  // ready/clearing read 0 while reset is held, even if the state register
  // already sits in its post-reset value.
  assign ready     = (state_q == S_IDLE)  && reset;
  assign clearing  = (state_q == S_CLEAR) && reset;
  assign accept    = req && ready;
  assign in_range  = ({1'b0, address} < DEPTH_C);
  assign mask_full = &mask;
  assign mask_none = ~|mask;

  // Merge word for the second half of a partial write: latched bytes where
  // enabled, otherwise the bytes read back from storage in the accept cycle.
  generate
    for (genvar gi = 0; gi < MW; gi++) begin : g_merge
      assign merged[8*gi +: 8] = lat_mask_q[gi] ? lat_data_q[8*gi +: 8]
                                                : mem_rd_q[8*gi +: 8];
    end
  endgenerate

  // Read data is the RAM output register during the valid cycle and a held
  // copy afterwards, so RMW reads into the RAM register never disturb it.
  assign data_out   = data_valid_q ? (rd_zero_q ? '0 : mem_rd_q) : hold_q;
  assign data_valid = data_valid_q;

  // Next-state, sweep counter, request decode and storage port control.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lat_addr_d     = lat_addr_q;
    lat_data_d     = lat_data_q;
    lat_mask_d     = lat_mask_q;
    lat_in_range_d = lat_in_range_q;
    data_valid_d   = 1'b0;
    rd_zero_d      = rd_zero_q;
    hold_d         = data_valid_q ? data_out : hold_q;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    mem_addr       = address[IW-1:0];
    mem_wdata      = data_in;

    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q[IW-1:0];
        mem_wdata = CLEAR_VALUE;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (accept) begin
          if (!write_enable) begin
            // Out-of-range reads still strobe, but return zero.
            data_valid_d = 1'b1;
            rd_zero_d    = !in_range;
            mem_re       = in_range;
          end else if (mask_full) begin
            mem_we = in_range;
          end else if (!mask_none) begin
            lat_addr_d     = address[IW-1:0];
            lat_data_d     = data_in;
            lat_mask_d     = mask;
            lat_in_range_d = in_range;
            mem_re         = in_range;
            state_d        = S_RMW;
          end
        end else if (clear_start) begin
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end

      S_RMW: begin
        mem_we    = lat_in_range_q;
        mem_addr  = lat_addr_q;
        mem_wdata = merged;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RESET_STATE;
      cnt_q          <= '0;
      lat_addr_q     <= '0;
      lat_data_q     <= '0;
      lat_mask_q     <= '0;
      lat_in_range_q <= 1'b0;
      data_valid_q   <= 1'b0;
      rd_zero_q      <= 1'b0;
      hold_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lat_addr_q     <= lat_addr_d;
      lat_data_q     <= lat_data_d;
      lat_mask_q     <= lat_mask_d;
      lat_in_range_q <= lat_in_range_d;
      data_valid_q   <= data_valid_d;
      rd_zero_q      <= rd_zero_d;
      hold_q         <= hold_d;
    end
  end

  // Single synchronous storage port: one write or one registered read per cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      storage[mem_addr] <= mem_wdata;
    end
    if (mem_re) begin
      mem_rd_q <= storage[mem_addr];
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: randomized + directed bench for ram_ctrl with a word-array
// reference model and a queue scoreboard drained by an independent monitor.
module tb_ram_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 12;   // one more bit than needed so out-of-range addresses exist
  localparam int DEPTH = 2048;
  localparam int MW    = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [MW-1:0] mask;
  logic          write_enable;
  logic          req;
  logic          ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          clear_start;
  logic          clearing;

  always #5 clk = ~clk;

  ram_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(1),
    .CLEAR_VALUE   (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .data_in     (data_in),
    .mask        (mask),
    .write_enable(write_enable),
    .req         (req),
    .ready       (ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .clear_start (clear_start),
    .clearing    (clearing)
  );

  int            checks = 0;
  int            errors = 0;
  int            last_wait = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_val;
  logic [DW-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as a plain word array, a write replaces the enabled bytes.
  task automatic model_apply(input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [MW-1:0] m);
    int idx;
    idx = int'(a);
    if (!we) begin
      if (idx < DEPTH) exp_q.push_back(ref_mem[idx]);
      else             exp_q.push_back('0);
    end else if (idx < DEPTH) begin
      for (int b = 0; b < MW; b++)
        if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Issue one request at a falling edge once ready; it is accepted at the next rising edge.
  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m, input bit cs);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 5000) begin
      req = 1'b0;
      clear_start = 1'b0;
      w++;
      @(negedge clk);
    end
    last_wait = w;
    if (!ready) begin
      chk("ready_timeout", 32'(ready), 32'd1);
    end else begin
      req = 1'b1; write_enable = we; address = a; data_in = d; mask = m; clear_start = cs;
      @(posedge clk);
      model_apply(we, a, d, m);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      req = 1'b0;
      clear_start = 1'b0;
    end
  endtask

  // Count falling edges with clearing high until ready rises (bounded).
  task automatic wait_clear(output int n);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ready) break;
      if (clearing) n++;
    end
  endtask

  // Hold reset for a few cycles, check reset values, release just after a rising edge.
  task automatic hold_reset();
    reset = 1'b0; req = 1'b0; clear_start = 1'b0;
    exp_q.delete();
    last_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_clearing", 32'(clearing), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Monitor: each falling edge out of reset, data_valid must match an outstanding
  // read; on a pulse compare against the scoreboard, otherwise data_out must hold.
  always @(negedge clk) begin
    if (reset) begin
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(data_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("read_data", 32'(data_out), 32'(mon_e));
          last_val = mon_e;
        end
      end else begin
        if (exp_q.size() != 0) begin
          chk("missing_valid", 32'(data_valid), 32'd1);
          mon_e = exp_q.pop_front();
          last_val = mon_e;
        end else begin
          chk("data_out_hold", 32'(data_out), 32'(last_val));
        end
      end
    end
  end

  initial begin
    int n;
    bit rw;
    logic [AW-1:0] ra;
    logic [MW-1:0] rm;
    int sel;

    reset = 1'b0; req = 1'b0; write_enable = 1'b0; address = '0;
    data_in = '0; mask = '0; clear_start = 1'b0; last_val = '0;

    // Power-up sweep
    hold_reset();
    wait_clear(n);
    chk("reset_clear_len", 32'(n), 32'(DEPTH));
    zero_model();
    do_req(1'b0, 12'h7FF, 16'h0, 2'b00, 1'b0);

    // Full write then read
    do_req(1'b1, 12'd5, 16'h1234, 2'b11, 1'b0);
    do_req(1'b0, 12'd5, 16'h0, 2'b00, 1'b0);
    idle(2);

    // Partial writes via read-modify-write
    do_req(1'b1, 12'd9, 16'hAABB, 2'b11, 1'b0);
    do_req(1'b1, 12'd9, 16'h1122, 2'b01, 1'b0);
    @(negedge clk);
    chk("rmw_ready_low", 32'(ready), 32'd0);
    do_req(1'b0, 12'd9, 16'h0, 2'b00, 1'b0);
    chk("rmw_ready_back", 32'(last_wait), 32'd0);
    do_req(1'b1, 12'd9, 16'h3300, 2'b10, 1'b0);
    @(negedge clk);
    chk("rmw2_ready_low", 32'(ready), 32'd0);
    do_req(1'b0, 12'd9, 16'h0, 2'b00, 1'b0);
    chk("rmw2_ready_back", 32'(last_wait), 32'd0);

    // Back-to-back reads
    do_req(1'b1, 12'd0, 16'h00A0, 2'b11, 1'b0);
    do_req(1'b1, 12'd1, 16'h0055, 2'b11, 1'b0);
    do_req(1'b1, 12'd2, 16'h0099, 2'b11, 1'b0);
    do_req(1'b1, 12'd3, 16'h0044, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) do_req(1'b0, 12'(i), 16'h0, 2'b00, 1'b0);
    idle(3);

    // clear_start coinciding with a read: read wins; then clear_start alone
    do_req(1'b0, 12'd5, 16'h0, 2'b00, 1'b1);
    @(negedge clk);
    chk("cs_with_req_no_clear", 32'(clearing), 32'd0);
    req = 1'b0;
    clear_start = 1'b1;
    @(posedge clk);
    #1 clear_start = 1'b0;
    wait_clear(n);
    chk("cs_clear_len", 32'(n), 32'(DEPTH));
    zero_model();

    // Randomized traffic, including mask 0, partial masks and out-of-range addresses
    for (int t = 0; t < 600; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      ra = AW'($urandom_range(0, 15));
      else if (sel < 8) ra = AW'($urandom_range(0, DEPTH - 1));
      else              ra = AW'($urandom_range(DEPTH, (1 << AW) - 1));
      rw = 1'($urandom_range(0, 1));
      rm = MW'($urandom_range(0, (1 << MW) - 1));
      do_req(rw, ra, DW'($urandom), rm, 1'b0);
      if ($urandom_range(0, 9) < 3) idle(1);
    end
    idle(3);

    // Reset in the cycle after a read accept
    do_req(1'b1, 12'd3, 16'hBEEF, 2'b11, 1'b0);
    do_req(1'b0, 12'd3, 16'h0, 2'b00, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("rst_after_read_valid", 32'(data_valid), 32'd0);
    chk("rst_after_read_data", 32'(data_out), 32'd0);
    hold_reset();

    // Reset pulsed 100 cycles into the sweep restarts it from the beginning
    repeat (100) @(posedge clk);
    #1;
    chk("mid_clear_active", 32'(clearing), 32'd1);
    hold_reset();
    wait_clear(n);
    chk("restart_clear_len", 32'(n), 32'(DEPTH));
    zero_model();
    do_req(1'b0, 12'd3, 16'h0, 2'b00, 1'b0);
    do_req(1'b0, 12'h7FF, 16'h0, 2'b00, 1'b0);
    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Parametrised successor to the on-chip 16-bit block RAM.
- Generic data width and depth, byte-lane write masks implemented as a read-modify-write sequence, a valid/ready request handshake, a read-data-valid strobe, and a hardware memory-clear sequencer that runs after reset or on demand.
- Sits between the F100-L core bus interface and inferred iCE40 BlockRAM. Storage uses a single synchronous port so the tools still infer BlockRAM.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 11, address bits.
- DEPTH, 2048, implemented words; must be <= 2**ADDR_WIDTH.
- CLEAR_ON_RESET, 1, if 1, run a clear sweep after reset deasserts.
- CLEAR_VALUE, 0, word written to every location during a clear sweep.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- address  input  ADDR_WIDTH  word address of the request.
- data_in  input  DATA_WIDTH  write data.
- mask  input  DATA_WIDTH/8  byte enables; bit i enables byte i (bits 8i+7:8i).
- write_enable  input  1  1 = write request, 0 = read request.
- req  input  1  request valid.
- ready  output  1  controller can accept a request this cycle.
- data_out  output reg  DATA_WIDTH  read data; holds its value until the next completed read.
- data_valid  output reg  1  one-cycle pulse when data_out is updated.
- clear_start  input  1  start a clear sweep; sampled only in IDLE.
- clearing  output  1  high while a clear sweep is in progress.

Behaviour:
- Reset is asserted while reset==0, asynchronously.
- Reset values: data_out=0, data_valid=0, ready=0, clearing=0, clear counter=0. Memory contents are not reset.
- The state register leaves reset as CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- A request is accepted on a rising edge where req & ready are both 1.
- ready = (state==IDLE). It is combinational from state only and never depends on req.
- States:
  - CLEAR:
    - Each cycle write CLEAR_VALUE to storage[cnt], then cnt++.
    - When cnt==DEPTH-1 is written, go to IDLE and reset cnt to 0.
    - clearing=1 and ready=0 throughout; the sweep takes exactly DEPTH cycles.
    - req is ignored.
  - IDLE:
    - Read accept: storage[address] is registered into data_out at the accept edge. data_valid=1 for the following cycle. Latency is 1 cycle. Back-to-back reads are allowed every cycle.
    - Write accept with mask all ones: storage[address]<=data_in at the accept edge. Remain in IDLE.
    - Write accept with mask==0: no-op. Remain in IDLE.
    - Partial write accept (mask neither 0 nor all ones):
      - Latch address, data_in and mask.
      - Read storage[address] into an internal merge register, not into data_out.
      - Go to RMW.
    - clear_start=1 with no request accepted: go to CLEAR.
    - If req & ready & clear_start coincide, the request wins and clear_start is dropped.
  - RMW:
    - ready=0.
    - Write merged word: byte i = latched mask[i] ? latched data_in byte i : merge register byte i.
    - Return to IDLE.
    - A partial write therefore occupies 2 cycles. The write is visible to a read accepted in the next IDLE cycle.
- data_valid never pulses for writes, the clear sweep, or RMW.
- Out-of-range addresses (address >= DEPTH):
  - Writes are discarded, including the RMW write.
  - Reads return 0 with data_valid=1.
- Reset mid-CLEAR: the sweep aborts and restarts from address 0 (if CLEAR_ON_RESET=1).
- Reset mid-RMW: the merged write is lost and the memory word is unchanged.
- Reset in the cycle after a read accept: data_valid and data_out are forced to 0.
- No address wrap: cnt is sized ADDR_WIDTH+1 internally so DEPTH=2**ADDR_WIDTH terminates correctly.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, DEPTH=2048 -> clearing=1 for exactly 2048 cycles, then ready=1. A read of 0x7FF returns 0x0000.
- Full write 0x1234 to address 5, then read address 5 the next cycle -> data_out=0x1234 with a single data_valid pulse one cycle after accept.
- Word 0xAABB at address 9; partial write of data 0x1122 with mask=2'b01 -> ready low for 1 cycle. A subsequent read returns 0xAA22. Then mask=2'b10 with data 0x3300 -> read returns 0x3322.
- Reads of addresses 0..3 on consecutive cycles after writing 0x00a0, 0x0055, 0x0099, 0x0044 -> data_valid high for 4 consecutive cycles, data_out in that order.
- Reset pulsed 100 cycles into a clear sweep -> the sweep restarts. ready stays low for a full 2048 cycles after release.
- clear_start asserted together with a read request in IDLE -> the read completes (data_valid pulse). No sweep starts (clearing stays 0). clear_start alone on the next cycle -> clearing=1 the following cycle.
